tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial `tx` output port between `NREQ` requesters, typically the router's input FIFOs contending for one output direction.
- Captures the winning flit into a one-entry hold register and acks (pops) the requester.
- Presents the held flit to `tx` using the `req`/`tx_busy` handshake.
- Prefetches the next winner while the current frame is still serialising.

---
 rtl/tx_arbiter_pkg.sv | 29 ++
 rtl/tx_arbiter_rr_picker.sv | 35 +++
 rtl/tx_arbiter.sv | 123 ++++++++++++
 tb/tb_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for tx_arbiter: flit geometry defaults (overridable from the
// command line), stats counter width, hold-state encoding and pointer sizing.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

package tx_arbiter_pkg;

   localparam int STATS_W = 16;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((32'sd1 <<< w) < n) begin
         w = w + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr_i,
// wrapping modulo NREQ. Returns both a one-hot grant and its binary index.
module rr_picker
   import tx_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] rr_ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [PTR_W-1:0] idx_o
);

   logic [PTR_W-1:0] cand_s;
   logic             hit_s;
   logic             found_s;

   // Visit rr_ptr+1 .. rr_ptr+NREQ; the last candidate is the previous winner itself.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found_s = 1'b0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s          = PTR_W'((int'(rr_ptr_i) + k) % NREQ);
         hit_s           = ~found_s & req_i[cand_s];
         grant_o[cand_s] = grant_o[cand_s] | hit_s;
         idx_o           = hit_s ? cand_s : idx_o;
         found_s         = found_s | hit_s;
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one serial tx port through a one-entry hold register.
// Optional per-requester grant counters are built when TX_ARB_STATS_EN is defined.
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int    NREQ     = 4,
   parameter int    routerid = -1,
   parameter string port     = "unknown",
   localparam int   FLIT_W   = `PAYLOAD_SIZE + `ADDR_SZ
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ*FLIT_W-1:0] req_data_i,
   output logic [NREQ-1:0]        ack_o,
   output logic                   tx_req_o,
   output logic [FLIT_W-1:0]      tx_data_o,
   input  logic                   tx_busy_i
`ifdef TX_ARB_STATS_EN
   ,
   output logic [NREQ*STATS_W-1:0] grant_cnt_o
`endif
);

   localparam int PTR_W = clog2(NREQ);

   if (NREQ < 2 || routerid < -1 || port == "") begin : g_bad_cfg
      $error("tx_arbiter: invalid configuration");
   end

   hold_state_e       state_q, state_d;
   logic [FLIT_W-1:0] data_q, data_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   grant_s;
   logic [PTR_W-1:0]  idx_s;
   logic              transfer_s;
   logic              capture_s;

   rr_picker #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req_i    (req_i),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (grant_s),
      .idx_o    (idx_s)
   );

   // A transfer is exactly tx's own accept condition; capture refills on the same edge.
   always_comb begin
      transfer_s = (state_q == HOLD_FULL) & ~tx_busy_i;
      capture_s  = ~reset_i & (|req_i) & ((state_q == HOLD_EMPTY) | transfer_s);
      ack_o      = capture_s ? grant_s : '0;
      tx_req_o   = (state_q == HOLD_FULL);
      tx_data_o  = data_q;
   end

   // Hold-register next state, data and round-robin pointer.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         HOLD_EMPTY: begin
            if (capture_s) state_d = HOLD_FULL;
            else           state_d = HOLD_EMPTY;
         end
         HOLD_FULL: begin
            if (transfer_s && !capture_s) state_d = HOLD_EMPTY;
            else                          state_d = HOLD_FULL;
         end
         default: state_d = HOLD_EMPTY;
      endcase
      if (capture_s) begin
         data_d   = req_data_i[idx_s*FLIT_W +: FLIT_W];
         rr_ptr_d = idx_s;
      end else begin
         data_d   = data_q;
         rr_ptr_d = rr_ptr_q;
      end
   end

   // Pointer resets to the last slot so requester 0 is favoured first.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= HOLD_EMPTY;
         data_q   <= '0;
         rr_ptr_q <= PTR_W'(NREQ - 1);
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef TX_ARB_STATS_EN
   logic [NREQ*STATS_W-1:0] cnt_q, cnt_d;

   // Saturating grant counters, one per requester.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NREQ; i++) begin
         if (ack_o[i] && (cnt_q[i*STATS_W +: STATS_W] != {STATS_W{1'b1}})) begin
            cnt_d[i*STATS_W +: STATS_W] = cnt_q[i*STATS_W +: STATS_W] + STATS_W'(1);
         end else begin
            cnt_d[i*STATS_W +: STATS_W] = cnt_q[i*STATS_W +: STATS_W];
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a behavioural tx serialiser (12-bit flits, 4 requesters).
module tb_tx_arbiter;

   localparam int FW = 12;

   logic          clk;
   logic          reset;
   logic [3:0]    req;
   logic [4*FW-1:0] req_data;
   logic [3:0]    ack;
   logic          tx_req;
   logic [FW-1:0] tx_data;
   logic          dut_busy;
`ifdef TX_ARB_STATS_EN
   logic [63:0]   grant_cnt;
`endif

   // tx model state
   logic [3:0]    tx_cnt;
   logic [FW-1:0] tx_sh;
   logic          channel_busy;
   logic          tx_bypass;
   logic          tx_busy_model;
   logic          serial_o;

   int            checks;
   int            errors;
   int            cyc;
   int            c0;
   logic [3:0]    ack_log[$];
   logic [FW-1:0] acc_data[$];
   int            acc_cyc[$];
   logic [3:0]    exp_ack_rr[5];
   logic [FW-1:0] exp_dat_rr[5];
   logic [3:0]    exp_ack_pr[4];

   tx_arbiter #(.NREQ(4)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .req_i      (req),
      .req_data_i (req_data),
      .ack_o      (ack),
      .tx_req_o   (tx_req),
      .tx_data_o  (tx_data),
      .tx_busy_i  (dut_busy)
`ifdef TX_ARB_STATS_EN
      ,
      .grant_cnt_o (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tx_busy_model = (tx_cnt != 4'd0) | channel_busy;
   assign dut_busy      = tx_bypass ? 1'b0 : tx_busy_model;
   assign serial_o      = (tx_cnt != 4'd0) ? tx_sh[0] : 1'b1;

   // Serialiser: accepts when not busy, then stays busy so accepts are 13 edges apart.
   always @(posedge clk) begin
      if (reset) begin
         tx_cnt <= 4'd0;
         tx_sh  <= '0;
      end else if (tx_req && !tx_busy_model) begin
         tx_cnt <= 4'd12;
         tx_sh  <= tx_data;
      end else if (tx_cnt != 4'd0) begin
         tx_cnt <= tx_cnt - 4'd1;
         tx_sh  <= tx_sh >> 1;
      end
   end

   // Edge recorder: acks and accepted flits, tagged with the edge number.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && !tx_bypass) begin
         if (tx_req && !dut_busy) begin
            acc_data.push_back(tx_data);
            acc_cyc.push_back(cyc);
         end
         if (ack != 4'd0) ack_log.push_back(ack);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'd0;
      @(negedge clk);
      reset = 1'b0;
      ack_log.delete();
      acc_data.delete();
      acc_cyc.delete();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && (tx_busy_model || tx_req); i++) @(negedge clk);
      chk("idle_timeout", {30'd0, tx_busy_model, tx_req}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      reset = 1'b1;
      req = 4'd0;
      req_data = '0;
      channel_busy = 1'b0;
      tx_bypass = 1'b0;
      exp_ack_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_dat_rr = '{12'h100, 12'h211, 12'h322, 12'h433, 12'h100};
      exp_ack_pr = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

      repeat (2) @(negedge clk);
      chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
      chk("rst_tx_data", {20'd0, tx_data}, 32'd0);
      chk("rst_ack", {28'd0, ack}, 32'd0);

      // Latency from idle.
      reset = 1'b0;
      req = 4'b0001;
      req_data[11:0] = 12'hA5C;
      c0 = cyc;
      #1 chk("lat_ack", {28'd0, ack}, 32'd1);
      @(negedge clk);
      chk("lat_tx_req", {31'd0, tx_req}, 32'd1);
      chk("lat_tx_data", {20'd0, tx_data}, 32'hA5C);
      req = 4'd0;
      #1 chk("lat_no_ack", {28'd0, ack}, 32'd0);
      @(negedge clk);
      chk("lat_acc_n", acc_data.size(), 32'd1);
      chk("lat_acc_data", {20'd0, acc_data[0]}, 32'hA5C);
      chk("lat_acc_edge", acc_cyc[0], c0 + 1);
      chk("lat_empty", {31'd0, tx_req}, 32'd0);
      wait_idle();

      // All four requesting: strict rotation at full tx rate.
      do_reset();
      req_data = {12'h433, 12'h322, 12'h211, 12'h100};
      req = 4'b1111;
      #1 chk("rr_first_ack", {28'd0, ack}, 32'd1);
      for (int i = 0; i < 200 && ack_log.size() < 5; i++) @(negedge clk);
      req = 4'd0;
      chk("rr_ack_count", ack_log.size(), 32'd5);
      for (int i = 0; i < 200 && acc_data.size() < 5; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("rr_acc_count", acc_data.size(), 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_ack%0d", k), {28'd0, ack_log[k]}, {28'd0, exp_ack_rr[k]});
         chk($sformatf("rr_dat%0d", k), {20'd0, acc_data[k]}, {20'd0, exp_dat_rr[k]});
      end
      for (int k = 1; k < 5; k++) chk($sformatf("rr_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], 32'd13);
      wait_idle();

      // Channel busy stalls the hold register; waiting requester not acked.
      ack_log.delete();
      acc_data.delete();
      acc_cyc.delete();
      channel_busy = 1'b1;
      req = 4'b0001;
      req_data[11:0]  = 12'h7E1;
      req_data[23:12] = 12'h2B4;
      #1 chk("cb_cap_ack", {28'd0, ack}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         req = 4'b0010;
         #1;
         chk("cb_no_ack", {28'd0, ack}, 32'd0);
         chk("cb_tx_req", {31'd0, tx_req}, 32'd1);
         chk("cb_tx_data", {20'd0, tx_data}, 32'h7E1);
      end
      channel_busy = 1'b0;
      c0 = cyc;
      #1 chk("cb_release_ack", {28'd0, ack}, 32'd2);
      @(negedge clk);
      req = 4'd0;
      chk("cb_acc_n", acc_data.size(), 32'd1);
      chk("cb_acc_data", {20'd0, acc_data[0]}, 32'h7E1);
      chk("cb_acc_edge", acc_cyc[0], c0);
      chk("cb_next_data", {20'd0, tx_data}, 32'h2B4);
      wait_idle();

      // Requesters 0 and 2 only, starting from rr_ptr=0.
      do_reset();
      req_data = {12'h3D3, 12'h2C2, 12'h1B1, 12'h0A0};
      req = 4'b0001;
      @(negedge clk);
      req = 4'b0101;
      #1 chk("pr_ack_first", {28'd0, ack}, 32'h4);
      for (int i = 0; i < 200 && ack_log.size() < 4; i++) @(negedge clk);
      req = 4'd0;
      chk("pr_ack_count", ack_log.size(), 32'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("pr_ack%0d", k), {28'd0, ack_log[k]}, {28'd0, exp_ack_pr[k]});

      // Reset while full and tx mid-frame.
      repeat (3) @(negedge clk);
      chk("mr_full", {31'd0, tx_req}, 32'd1);
      chk("mr_tx_active", {31'd0, tx_busy_model}, 32'd1);
      reset = 1'b1;
      req = 4'b1111;
      #1 chk("mr_ack_in_reset", {28'd0, ack}, 32'd0);
      @(negedge clk);
      chk("mr_tx_req", {31'd0, tx_req}, 32'd0);
      chk("mr_ack", {28'd0, ack}, 32'd0);
      chk("mr_serial_idle", {31'd0, serial_o}, 32'd1);
      chk("mr_tx_abort", {31'd0, tx_busy_model}, 32'd0);
      reset = 1'b0;
      #1 chk("mr_first_grant", {28'd0, ack}, 32'd1);
      @(negedge clk);
      req = 4'd0;
      wait_idle();

`ifdef TX_ARB_STATS_EN
      // Grant counters, including saturation.
      do_reset();
      chk("st_reset", grant_cnt[31:0] | grant_cnt[63:32], 32'd0);
      tx_bypass = 1'b1;
      req = 4'b0101;
      repeat (10) @(negedge clk);
      req = 4'b0010;
      repeat (70000) @(negedge clk);
      req = 4'd0;
      @(negedge clk);
      tx_bypass = 1'b0;
      chk("st_cnt0", {16'd0, grant_cnt[15:0]}, 32'd5);
      chk("st_cnt1", {16'd0, grant_cnt[31:16]}, 32'hFFFF);
      chk("st_cnt2", {16'd0, grant_cnt[47:32]}, 32'd5);
      chk("st_cnt3", {16'd0, grant_cnt[63:48]}, 32'd0);
      wait_idle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
